// File: rtl/bram_responder_pkg.sv
// Shared widths and response-queue sizing for bram_responder.
package bram_responder_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 10;
  localparam int RSP_DEPTH = 3;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/bram_responder_fifo.sv
// sync_fifo: small in-order queue with occupancy count.
module sync_fifo
  import bram_responder_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = RSP_DEPTH,
  localparam int CW = cnt_w(DEPTH),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push_i & (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i & (cnt_q != '0);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = bump(wr_q);
    if (do_pop)  rd_d = bump(rd_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/bram_responder.sv
// Valid/ready request front-end for one port of a registered-read BRAM.
module bram_responder
  import bram_responder_pkg::*;
#(
  parameter int P_DATA_WIDTH    = DATA_W,
  parameter int P_ADDRESS_WIDTH = ADDR_W
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_REQ_VALID,
  output logic                       O_REQ_READY,
  input  logic                       I_REQ_WRITE,
  input  logic [P_ADDRESS_WIDTH-1:0] I_REQ_ADDRESS,
  input  logic [P_DATA_WIDTH-1:0]    I_REQ_DATA,
  output logic                       O_RSP_VALID,
  input  logic                       I_RSP_READY,
  output logic [P_DATA_WIDTH-1:0]    O_RSP_DATA,
  output logic                       O_RSP_WRITE,
  output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS,
  output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA,
  output logic                       O_BRAM_WRITE_ENABLE,
  input  logic [P_DATA_WIDTH-1:0]    I_BRAM_DATA
);
  localparam int CW = cnt_w(RSP_DEPTH);
  localparam logic [CW:0] OCC_MAX = (CW+1)'(RSP_DEPTH);

  logic                       run_q;
  logic                       busy_q;
  logic                       wr_q, wr_d;
  logic [P_DATA_WIDTH-1:0]    data_q, data_d;
  logic [P_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                       accept;
  logic                       pop;
  logic                       empty;
  logic [CW-1:0]              count;
  logic [CW:0]                occ;
  logic [P_DATA_WIDTH:0]      push_data;
  logic [P_DATA_WIDTH:0]      head;

  // Ready counts queued plus in-flight results; registered state only.
  assign occ         = {1'b0, count} + (CW+1)'(busy_q);
  assign O_REQ_READY = run_q & (occ < OCC_MAX);
  assign accept      = I_REQ_VALID & O_REQ_READY;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wr_d   = wr_q;
    if (accept) begin
      addr_d = I_REQ_ADDRESS;
      data_d = I_REQ_DATA;
      wr_d   = I_REQ_WRITE;
    end
  end

  assign O_BRAM_ADDRESS      = addr_d;
  assign O_BRAM_DATA         = data_d;
  assign O_BRAM_WRITE_ENABLE = accept & I_REQ_WRITE;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      run_q  <= 1'b0;
      busy_q <= 1'b0;
      wr_q   <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      run_q  <= 1'b1;
      busy_q <= accept;
      wr_q   <= wr_d;
      data_q <= data_d;
      addr_q <= addr_d;
    end
  end

  // BRAM read data is valid the cycle after the address was presented.
  assign push_data = {wr_q, wr_q ? data_q : I_BRAM_DATA};
  assign pop       = ~empty & I_RSP_READY;

  sync_fifo #(
    .WIDTH(P_DATA_WIDTH + 1),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i  (I_CLK),
    .rst_ni (I_NRESET),
    .push_i (busy_q),
    .data_i (push_data),
    .pop_i  (pop),
    .data_o (head),
    .count_o(count),
    .empty_o(empty)
  );

  assign O_RSP_VALID = ~empty;
  assign O_RSP_WRITE = head[P_DATA_WIDTH];
  assign O_RSP_DATA  = head[P_DATA_WIDTH-1:0];
endmodule

// File: tb/tb_bram_responder.sv
// Bench for bram_responder: queue model of outstanding responses plus directed cases.
module tb_bram_responder;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          I_CLK = 1'b0;
  logic          I_NRESET = 1'b0;
  logic          I_REQ_VALID = 1'b0;
  logic          O_REQ_READY;
  logic          I_REQ_WRITE = 1'b0;
  logic [AW-1:0] I_REQ_ADDRESS = '0;
  logic [DW-1:0] I_REQ_DATA = '0;
  logic          O_RSP_VALID;
  logic          I_RSP_READY = 1'b0;
  logic [DW-1:0] O_RSP_DATA;
  logic          O_RSP_WRITE;
  logic [AW-1:0] O_BRAM_ADDRESS;
  logic [DW-1:0] O_BRAM_DATA;
  logic          O_BRAM_WRITE_ENABLE;
  logic [DW-1:0] I_BRAM_DATA;

  always #5 I_CLK = ~I_CLK;

  bram_responder dut (
    .I_CLK              (I_CLK),
    .I_NRESET           (I_NRESET),
    .I_REQ_VALID        (I_REQ_VALID),
    .O_REQ_READY        (O_REQ_READY),
    .I_REQ_WRITE        (I_REQ_WRITE),
    .I_REQ_ADDRESS      (I_REQ_ADDRESS),
    .I_REQ_DATA         (I_REQ_DATA),
    .O_RSP_VALID        (O_RSP_VALID),
    .I_RSP_READY        (I_RSP_READY),
    .O_RSP_DATA         (O_RSP_DATA),
    .O_RSP_WRITE        (O_RSP_WRITE),
    .O_BRAM_ADDRESS     (O_BRAM_ADDRESS),
    .O_BRAM_DATA        (O_BRAM_DATA),
    .O_BRAM_WRITE_ENABLE(O_BRAM_WRITE_ENABLE),
    .I_BRAM_DATA        (I_BRAM_DATA)
  );

  // Attached BRAM port: synchronous write, registered read-before-write.
  logic [DW-1:0] bram [1024];
  logic [DW-1:0] bram_q = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge I_CLK) begin
    if (pl_en) bram[pl_addr] <= pl_data;
    else if (O_BRAM_WRITE_ENABLE) bram[O_BRAM_ADDRESS] <= O_BRAM_DATA;
    bram_q <= bram[O_BRAM_ADDRESS];
  end
  assign I_BRAM_DATA = bram_q;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    int            vis;
  } exp_t;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    int            cyc;
  } log_t;

  exp_t          exp_q[$];
  log_t          log_q[$];
  logic [DW-1:0] shadow [1024];
  logic [AW-1:0] last_addr = '0;
  int            cyc = 0;
  int            since_rst = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input logic w, input logic [DW-1:0] d);
    if (idx >= log_q.size()) begin
      chk({nm, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      chk({nm, "_data"}, 32'(log_q[idx].d), 32'(d));
      chk({nm, "_write"}, 32'(log_q[idx].w), 32'(w));
    end
  endtask

  always @(posedge I_CLK) begin
    cyc++;
    if (I_NRESET) since_rst++;
    else since_rst = 0;
  end

  // Model: one queue entry per accepted, not yet consumed request.
  always @(negedge I_CLK) begin
    logic er, ev, acc;
    if (!I_NRESET) begin
      chk("rst_req_ready", 32'(O_REQ_READY), 0);
      chk("rst_rsp_valid", 32'(O_RSP_VALID), 0);
      chk("rst_bram_we", 32'(O_BRAM_WRITE_ENABLE), 0);
      chk("rst_rsp_data", 32'(O_RSP_DATA), 0);
      chk("rst_rsp_write", 32'(O_RSP_WRITE), 0);
      chk("rst_bram_addr", 32'(O_BRAM_ADDRESS), 0);
      chk("rst_bram_data", 32'(O_BRAM_DATA), 0);
      exp_q.delete();
      last_addr = '0;
    end else begin
      er  = (since_rst >= 1) && (exp_q.size() < 3);
      ev  = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
      acc = I_REQ_VALID && er;
      chk("req_ready", 32'(O_REQ_READY), 32'(er));
      chk("rsp_valid", 32'(O_RSP_VALID), 32'(ev));
      if (ev) begin
        chk("rsp_data", 32'(O_RSP_DATA), 32'(exp_q[0].d));
        chk("rsp_write", 32'(O_RSP_WRITE), 32'(exp_q[0].w));
      end
      chk("bram_we", 32'(O_BRAM_WRITE_ENABLE), 32'(acc && I_REQ_WRITE));
      if (acc) begin
        chk("bram_addr", 32'(O_BRAM_ADDRESS), 32'(I_REQ_ADDRESS));
        chk("bram_data", 32'(O_BRAM_DATA), 32'(I_REQ_DATA));
      end else begin
        chk("bram_addr_hold", 32'(O_BRAM_ADDRESS), 32'(last_addr));
      end
      if (ev && I_RSP_READY) begin
        log_q.push_back('{w: exp_q[0].w, d: exp_q[0].d, cyc: cyc + 1});
        void'(exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back('{w: I_REQ_WRITE,
                          d: I_REQ_WRITE ? I_REQ_DATA : shadow[I_REQ_ADDRESS],
                          vis: cyc + 2});
        if (I_REQ_WRITE) shadow[I_REQ_ADDRESS] = I_REQ_DATA;
        last_addr = I_REQ_ADDRESS;
      end
    end
  end

  task automatic set_req(input logic w, input int a, input logic [DW-1:0] d);
    I_REQ_VALID   = 1'b1;
    I_REQ_WRITE   = w;
    I_REQ_ADDRESS = AW'(a);
    I_REQ_DATA    = d;
  endtask

  task automatic do_req(input logic w, input int a, input logic [DW-1:0] d);
    logic r;
    int   n;
    set_req(w, a, d);
    r = 1'b0;
    n = 0;
    while (!r && n < 20) begin
      @(negedge I_CLK);
      r = O_REQ_READY;
      @(posedge I_CLK);
      #1;
      n++;
    end
    if (!r) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    pl_en     = 1'b1;
    pl_addr   = AW'(a);
    pl_data   = d;
    shadow[a] = d;
    @(posedge I_CLK);
    #1;
    pl_en = 1'b0;
  endtask

  int t4_w [5] = '{1, 1, 0, 0, 1};
  int t4_a [5] = '{10, 11, 10, 11, 12};
  int t4_d [5] = '{16'h1111, 16'h2222, 0, 0, 16'h3333};

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n0, c0, k, nacc;
    logic r;

    repeat (3) @(posedge I_CLK);
    #1;
    chk("lit_rst_ready", 32'(O_REQ_READY), 0);
    I_NRESET = 1'b1;
    @(negedge I_CLK);
    chk("lit_ready_pre_edge", 32'(O_REQ_READY), 0);
    @(negedge I_CLK);
    chk("lit_ready_post_edge", 32'(O_REQ_READY), 1);
    @(posedge I_CLK);
    #1;

    preload(1, 16'h0002);
    I_RSP_READY = 1'b1;
    do_req(1'b0, 1, '0);
    I_REQ_VALID = 1'b0;
    @(negedge I_CLK);
    chk("lit_read_valid_n1", 32'(O_RSP_VALID), 0);
    @(negedge I_CLK);
    chk("lit_read_valid_n2", 32'(O_RSP_VALID), 1);
    chk("lit_read_data", 32'(O_RSP_DATA), 32'h0002);
    chk("lit_read_write", 32'(O_RSP_WRITE), 0);
    @(posedge I_CLK);
    #1;

    n0 = log_q.size();
    do_req(1'b1, 1023, 16'h00AA);
    do_req(1'b0, 1023, '0);
    I_REQ_VALID = 1'b0;
    repeat (5) @(posedge I_CLK);
    #1;
    chk_log("lit_wr1023", n0, 1'b1, 16'h00AA);
    chk_log("lit_rd1023", n0 + 1, 1'b0, 16'h00AA);

    I_RSP_READY = 1'b0;
    k    = 0;
    nacc = 0;
    set_req(t4_w[0][0], t4_a[0], t4_d[0][DW-1:0]);
    repeat (8) begin
      @(negedge I_CLK);
      r = O_REQ_READY;
      @(posedge I_CLK);
      #1;
      if (r && I_REQ_VALID) begin
        nacc++;
        k++;
        if (k < 5) set_req(t4_w[k][0], t4_a[k], t4_d[k][DW-1:0]);
        else I_REQ_VALID = 1'b0;
      end
    end
    @(negedge I_CLK);
    chk("lit_bp_accepts", 32'(nacc), 3);
    chk("lit_bp_ready", 32'(O_REQ_READY), 0);
    chk("lit_bp_valid", 32'(O_RSP_VALID), 1);
    chk("lit_bp_data", 32'(O_RSP_DATA), 32'h1111);
    chk("lit_bp_write", 32'(O_RSP_WRITE), 1);
    repeat (2) @(negedge I_CLK);
    chk("lit_bp_hold", 32'(O_RSP_DATA), 32'h1111);
    @(posedge I_CLK);
    #1;
    I_REQ_VALID = 1'b0;
    n0 = log_q.size();
    I_RSP_READY = 1'b1;
    repeat (5) @(posedge I_CLK);
    #1;
    chk("lit_bp_drained", 32'(log_q.size() - n0), 3);
    chk_log("lit_bp0", n0, 1'b1, 16'h1111);
    chk_log("lit_bp1", n0 + 1, 1'b1, 16'h2222);
    chk_log("lit_bp2", n0 + 2, 1'b0, 16'h1111);

    for (int i = 0; i < 16; i++) preload(i, 16'h0100 + 16'(i));
    n0 = log_q.size();
    c0 = cyc;
    for (int i = 0; i < 16; i++) do_req(1'b0, i, '0);
    chk("lit_stream_cycles", 32'(cyc - c0), 16);
    I_REQ_VALID = 1'b0;
    repeat (5) @(posedge I_CLK);
    #1;
    chk("lit_stream_count", 32'(log_q.size() - n0), 16);
    for (int i = 0; i < 16; i++) chk_log("lit_stream", n0 + i, 1'b0, 16'h0100 + 16'(i));
    if (log_q.size() >= n0 + 16)
      chk("lit_stream_gapless", 32'(log_q[n0+15].cyc - log_q[n0].cyc), 15);

    do_req(1'b1, 500, 16'hBEEF);
    I_REQ_VALID = 1'b0;
    repeat (4) @(posedge I_CLK);
    #1;
    I_RSP_READY = 1'b0;
    do_req(1'b0, 1, '0);
    do_req(1'b0, 2, '0);
    do_req(1'b0, 3, '0);
    I_REQ_VALID = 1'b0;
    I_NRESET = 1'b0;
    #1;
    chk("lit_midrst_valid", 32'(O_RSP_VALID), 0);
    chk("lit_midrst_ready", 32'(O_REQ_READY), 0);
    repeat (2) @(posedge I_CLK);
    #1;
    I_NRESET = 1'b1;
    I_RSP_READY = 1'b1;
    @(posedge I_CLK);
    #1;
    n0 = log_q.size();
    do_req(1'b0, 500, '0);
    I_REQ_VALID = 1'b0;
    repeat (4) @(posedge I_CLK);
    #1;
    chk("lit_post_rst_count", 32'(log_q.size() - n0), 1);
    chk_log("lit_post_rst", n0, 1'b0, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
